// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch button front end.
// Holds the control FSM state type, the button bit positions used on the
// 4-bit level/press/release buses, and a counter-width helper.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAP   = 2'd3
    } sw_state_e;

    localparam int NUM_BTNS      = 4;
    localparam int BTN_IDX_N     = 0;  // BTN_N, the active-low button
    localparam int BTN_IDX_START = 1;  // BTN1, start/stop
    localparam int BTN_IDX_LAP   = 2;  // BTN2, lap
    localparam int BTN_IDX_CLEAR = 3;  // BTN3, clear

    // Bits needed to hold the values 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchronizer, debounce counter, debounced level
// and single-cycle press/release pulses. ACTIVE_LOW selects a pin whose idle
// level is 1; the synchronizer resets to that idle value and the level is
// reported active-high.
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = 120000,
    parameter logic ACTIVE_LOW      = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam int              CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          pressed_s;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          level_q;
    logic          level_d;
    logic          press_q;
    logic          press_d;
    logic          release_q;
    logic          release_d;

    // Two-stage synchronizer; resets to the released pin value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= ACTIVE_LOW;
            sync2_q <= ACTIVE_LOW;
        end else begin
            sync1_q <= pin_i;
            sync2_q <= sync1_q;
        end
    end

    assign pressed_s = sync2_q ^ ACTIVE_LOW;

    // Count consecutive mismatches; flip the level after DEBOUNCE_CYCLES of them.
    always_comb begin
        cnt_d     = '0;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (pressed_s != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d   = pressed_s;
                press_d   = pressed_s;
                release_d = !pressed_s;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Debounce state and registered edge pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/btn_event_reader.sv
// Stopwatch button reader: four debounced button channels feeding a small
// IDLE/RUN/PAUSE/LAP control FSM with a registered clear pulse.
// Optional feature: define BTN_LONG_PRESS_EN to build the BTN_N hold timer,
// which fires long_press and clear once per hold and forces IDLE.
module btn_event_reader
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = 120000,
    parameter int LONG_PRESS_CYCLES = 12000000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       BTN_N,
    input  logic       BTN1,
    input  logic       BTN2,
    input  logic       BTN3,
    output logic [3:0] btn_level,
    output logic [3:0] btn_press,
    output logic [3:0] btn_release,
    output logic       run,
    output logic       lap_freeze,
    output logic       clear,
    output logic       long_press
);

    logic [NUM_BTNS-1:0] raw_pins;
    sw_state_e           state_q;
    sw_state_e           state_d;
    logic                clear_q;
    logic                clear_d;
    logic                long_fire_s;

    assign raw_pins = {BTN3, BTN2, BTN1, BTN_N};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .ACTIVE_LOW      (gi == BTN_IDX_N)
            ) u_debounce (
                .clk       (CLK),
                .rst_n     (RST_N),
                .pin_i     (raw_pins[gi]),
                .level_o   (btn_level[gi]),
                .press_o   (btn_press[gi]),
                .release_o (btn_release[gi])
            );
        end
    endgenerate

`ifdef BTN_LONG_PRESS_EN
    localparam int            HW        = cnt_width(LONG_PRESS_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);

    logic [HW-1:0] hold_cnt_q;
    logic [HW-1:0] hold_cnt_d;
    logic          fired_q;
    logic          fired_d;
    logic          long_press_q;

    assign long_fire_s = btn_level[BTN_IDX_N] && !fired_q && (hold_cnt_q == HOLD_LAST);

    // Time the BTN_N hold; fire once, then wait for release before re-arming.
    always_comb begin
        hold_cnt_d = '0;
        fired_d    = 1'b0;
        if (btn_level[BTN_IDX_N]) begin
            fired_d = fired_q | long_fire_s;
            if (!fired_q && !long_fire_s) begin
                hold_cnt_d = hold_cnt_q + HW'(1);
            end
        end
    end

    // Hold timer state and registered long-press pulse.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hold_cnt_q   <= '0;
            fired_q      <= 1'b0;
            long_press_q <= 1'b0;
        end else begin
            hold_cnt_q   <= hold_cnt_d;
            fired_q      <= fired_d;
            long_press_q <= long_fire_s;
        end
    end

    assign long_press = long_press_q;
`else
    // No hold timer in this build; LONG_PRESS_CYCLES has no effect here.
    if (LONG_PRESS_CYCLES < 1) begin : g_long_press_unused
    end

    assign long_fire_s = 1'b0;
    assign long_press  = 1'b0;
`endif

    // Next state: long press overrides everything, then BTN3 > BTN1 > BTN2.
    always_comb begin
        state_d = state_q;
        clear_d = 1'b0;
        if (long_fire_s) begin
            state_d = ST_IDLE;
            clear_d = 1'b1;
        end else if (btn_press[BTN_IDX_CLEAR]) begin
            if (state_q == ST_IDLE || state_q == ST_PAUSE) begin
                state_d = ST_IDLE;
                clear_d = 1'b1;
            end
        end else if (btn_press[BTN_IDX_START]) begin
            case (state_q)
                ST_IDLE:  state_d = ST_RUN;
                ST_RUN:   state_d = ST_PAUSE;
                ST_PAUSE: state_d = ST_RUN;
                ST_LAP:   state_d = ST_PAUSE;
                default:  state_d = ST_IDLE;
            endcase
        end else if (btn_press[BTN_IDX_LAP]) begin
            case (state_q)
                ST_RUN:  state_d = ST_LAP;
                ST_LAP:  state_d = ST_RUN;
                default: state_d = state_q;
            endcase
        end
    end

    // Control state register; clear is registered alongside the state change.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            clear_q <= 1'b0;
        end else begin
            state_q <= state_d;
            clear_q <= clear_d;
        end
    end

    assign run        = (state_q == ST_RUN) || (state_q == ST_LAP);
    assign lap_freeze = (state_q == ST_LAP);
    assign clear      = clear_q;

endmodule

// File: tb/tb_btn_event_reader.sv
// Bench for btn_event_reader with DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20.
// A behavioural model predicts every output each cycle; directed scenarios
// add literal expectations. Long-press checks follow BTN_LONG_PRESS_EN.
module tb_btn_event_reader;

    localparam int D  = 4;
    localparam int LP = 20;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_LAP   = 3;

    logic       CLK   = 1'b0;
    logic       RST_N = 1'b0;
    logic       BTN_N = 1'b1;
    logic       BTN1  = 1'b0;
    logic       BTN2  = 1'b0;
    logic       BTN3  = 1'b0;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic [3:0] btn_release;
    logic       run;
    logic       lap_freeze;
    logic       clear;
    logic       long_press;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int clear_cnt = 0;
    int long_cnt  = 0;
    int press_cnt [4];

    // Model state
    logic       hist [4][D+1];
    logic [3:0] m_level;
    logic [3:0] m_press;
    logic [3:0] m_release;
    logic       m_clear;
    logic       m_long;
    int         m_mode;
`ifdef BTN_LONG_PRESS_EN
    int         m_held;
    logic       m_fired;
`endif

    logic [15:0] act_vec;
    logic [15:0] exp_vec;

    btn_event_reader #(
        .DEBOUNCE_CYCLES   (D),
        .LONG_PRESS_CYCLES (LP)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .BTN_N       (BTN_N),
        .BTN1        (BTN1),
        .BTN2        (BTN2),
        .BTN3        (BTN3),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .run         (run),
        .lap_freeze  (lap_freeze),
        .clear       (clear),
        .long_press  (long_press)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    assign act_vec = {btn_level, btn_press, btn_release, run, lap_freeze, clear, long_press};
    assign exp_vec = {m_level, m_press, m_release,
                      (m_mode == M_RUN || m_mode == M_LAP), (m_mode == M_LAP), m_clear, m_long};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < 4; ch++)
            for (int k = 0; k <= D; k++) hist[ch][k] = 1'b0;
        m_level   = '0;
        m_press   = '0;
        m_release = '0;
        m_clear   = 1'b0;
        m_long    = 1'b0;
        m_mode    = M_IDLE;
`ifdef BTN_LONG_PRESS_EN
        m_held    = 0;
        m_fired   = 1'b0;
`endif
    endtask

    // One clock of the model: control reacts to the pulses visible before the
    // edge; a level flips once its last D synchronized samples all disagree.
    task automatic model_step();
        logic [3:0] pins;
        logic       fire;
        logic       all_diff;
        int         nxt;
        pins = {BTN3, BTN2, BTN1, ~BTN_N};
        fire = 1'b0;
`ifdef BTN_LONG_PRESS_EN
        if (m_level[0]) begin
            m_held = m_held + 1;
            if (m_held == LP && !m_fired) begin
                fire    = 1'b1;
                m_fired = 1'b1;
            end
        end else begin
            m_held  = 0;
            m_fired = 1'b0;
        end
`endif
        nxt     = m_mode;
        m_clear = 1'b0;
        m_long  = fire;
        if (fire) begin
            nxt     = M_IDLE;
            m_clear = 1'b1;
        end else if (m_press[3]) begin
            if (m_mode == M_IDLE || m_mode == M_PAUSE) begin
                nxt     = M_IDLE;
                m_clear = 1'b1;
            end
        end else if (m_press[1]) begin
            nxt = (m_mode == M_RUN || m_mode == M_LAP) ? M_PAUSE : M_RUN;
        end else if (m_press[2]) begin
            if (m_mode == M_RUN) nxt = M_LAP;
            else if (m_mode == M_LAP) nxt = M_RUN;
        end
        m_mode = nxt;
        for (int ch = 0; ch < 4; ch++) begin
            all_diff = 1'b1;
            for (int k = 1; k <= D; k++)
                if (hist[ch][k] == m_level[ch]) all_diff = 1'b0;
            m_press[ch]   = all_diff && !m_level[ch];
            m_release[ch] = all_diff && m_level[ch];
            if (all_diff) m_level[ch] = !m_level[ch];
            for (int k = D; k >= 1; k--) hist[ch][k] = hist[ch][k-1];
            hist[ch][0] = pins[ch];
        end
    endtask

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) model_reset();
        else        model_step();
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge CLK) check("outputs", {16'h0, act_vec}, {16'h0, exp_vec});

    // Pulse counters, sampled on the edge after each pulse.
    always @(posedge CLK) begin
        if (RST_N) begin
            clear_cnt <= clear_cnt + int'(clear);
            long_cnt  <= long_cnt + int'(long_press);
            for (int i = 0; i < 4; i++) press_cnt[i] <= press_cnt[i] + int'(btn_press[i]);
        end
    end

    task automatic goto(input int k);
        while (cyc < k) @(negedge CLK);
    endtask

    task automatic set_pins(input logic [3:0] mask, input logic on);
        if (mask[0]) BTN_N = !on;
        if (mask[1]) BTN1  = on;
        if (mask[2]) BTN2  = on;
        if (mask[3]) BTN3  = on;
    endtask

    task automatic pulse(input string what, input logic [3:0] mask, input int hold);
        set_pins(mask, 1'b1);
        repeat (hold) @(negedge CLK);
        set_pins(mask, 1'b0);
        repeat (D + 6) @(negedge CLK);
        $display("%-12s mask=%b hold=%0d : run=%b lap_freeze=%b clears=%0d long=%0d",
                 what, mask, hold, run, lap_freeze, clear_cnt, long_cnt);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, required finish before 100000 ns");
        $fatal(1, "bench timeout");
    end

    initial begin
        int c0;
        int l0;
        int p0;
        int ptot;
        for (int i = 0; i < 4; i++) press_cnt[i] = 0;

        // Reset state
        goto(2);
        check("reset_outputs", {16'h0, act_vec}, 32'h0);
        goto(3);
        RST_N = 1'b1;

        // 3-sample glitch on BTN1: no level change, stays IDLE
        goto(4);
        BTN1 = 1'b1;
        goto(7);
        BTN1 = 1'b0;
        goto(10);
        check("glitch_level", {28'h0, btn_level}, 32'h0);
        check("glitch_presses", press_cnt[1], 0);
        check("glitch_run", {31'h0, run}, 32'h0);
        $display("glitch       BTN1 3 samples : level=%b run=%b", btn_level, run);

        // BTN1 high after edge 10: level and press at edge 16, run from 17
        BTN1 = 1'b1;
        goto(15);
        check("e15_level1", {31'h0, btn_level[1]}, 32'h0);
        goto(16);
        check("e16_level1", {31'h0, btn_level[1]}, 32'h1);
        check("e16_press1", {31'h0, btn_press[1]}, 32'h1);
        check("e16_run", {31'h0, run}, 32'h0);
        goto(17);
        check("e17_press1", {31'h0, btn_press[1]}, 32'h0);
        check("e17_run", {31'h0, run}, 32'h1);
        BTN1 = 1'b0;
        repeat (D + 6) @(negedge CLK);
        $display("start        BTN1 held      : level=%b run=%b", btn_level, run);

        // Lap toggling in RUN
        pulse("lap", 4'b0100, D + 4);
        check("lap_freeze_on", {30'h0, lap_freeze, run}, 32'h3);
        pulse("lap", 4'b0100, D + 4);
        check("lap_freeze_off", {30'h0, lap_freeze, run}, 32'h1);

        // Clear ignored in RUN, honoured in PAUSE
        c0 = clear_cnt;
        pulse("clear_run", 4'b1000, D + 4);
        check("clear_ignored_run", clear_cnt, c0);
        check("run_after_clear_run", {31'h0, run}, 32'h1);
        pulse("pause", 4'b0010, D + 4);
        check("pause_outputs", {30'h0, lap_freeze, run}, 32'h0);
        c0 = clear_cnt;
        pulse("clear_pause", 4'b1000, D + 4);
        check("clear_once_pause", clear_cnt, c0 + 1);
        check("idle_after_clear", {30'h0, lap_freeze, run}, 32'h0);

        // BTN2 ignored in IDLE; exactly-D pulse debounces, D-1 pulse does not
        p0 = press_cnt[2];
        pulse("lap_idle_D", 4'b0100, D);
        check("d_pulse_presses", press_cnt[2], p0 + 1);
        check("lap_idle_ignored", {30'h0, lap_freeze, run}, 32'h0);
        pulse("lap_idle_D-1", 4'b0100, D - 1);
        check("short_pulse_presses", press_cnt[2], p0 + 1);

        // BTN1 and BTN3 together in PAUSE: clear wins
        pulse("start", 4'b0010, D + 4);
        check("run_from_idle", {31'h0, run}, 32'h1);
        pulse("pause", 4'b0010, D + 4);
        check("paused", {31'h0, run}, 32'h0);
        c0 = clear_cnt;
        pulse("start+clear", 4'b1010, D + 4);
        check("both_clear_pulse", clear_cnt, c0 + 1);
        check("both_run", {31'h0, run}, 32'h0);

        // BTN1 and BTN2 together in RUN: start/stop wins
        pulse("start", 4'b0010, D + 4);
        pulse("start+lap", 4'b0110, D + 4);
        check("start_over_lap", {30'h0, lap_freeze, run}, 32'h0);
        pulse("start", 4'b0010, D + 4);
        check("run_again", {31'h0, run}, 32'h1);

        // Long BTN_N hold in RUN
        c0 = clear_cnt;
        l0 = long_cnt;
        pulse("hold_btn_n", 4'b0001, 40);
`ifdef BTN_LONG_PRESS_EN
        check("long_press_once", long_cnt, l0 + 1);
        check("long_clear_once", clear_cnt, c0 + 1);
        check("long_idle", {31'h0, run}, 32'h0);
`else
        check("no_long_press", long_cnt, l0);
        check("no_long_clear", clear_cnt, c0);
        check("hold_keeps_run", {31'h0, run}, 32'h1);
`endif

        // Reset in the middle of a BTN_N hold
        if (!run) pulse("start", 4'b0010, D + 4);
        BTN_N = 1'b0;
        repeat (D + 10) @(negedge CLK);
        @(posedge CLK);
        #1 RST_N = 1'b0;
        #1 check("async_reset_outputs", {16'h0, act_vec}, 32'h0);
        $display("reset        mid-hold       : outputs=%h", act_vec);
        @(negedge CLK);
        BTN_N = 1'b1;
        ptot = press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3];
        l0 = long_cnt;
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        repeat (30) @(negedge CLK);
        check("post_reset_level", {28'h0, btn_level}, 32'h0);
        check("post_reset_presses", press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3], ptot);
        check("post_reset_long", long_cnt, l0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
